hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage MIPS core: IF, ID, EX, MEM, WB.
- Detects load-use hazards and generates stall enables; the forwarding unit covers all other data hazards.
- Generates flushes for control redirects resolved in MEM: taken beq/bne, j/jal, jr.
- Supports an external freeze (single-step/debug).
- Tracks a valid bit per pipeline stage and keeps saturating performance counters.
- Sits beside the forwarding unit and drives enable/flush inputs on PC_Register and all four pipeline registers.

Parameters:
CNT_WIDTH, 32, width of each performance counter.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
ID_Rs  in  5  IF/ID instruction [25:21].
ID_Rt  in  5  IF/ID instruction [20:16].
ID_EX_MemRead  in  1  load in EX.
ID_EX_Rt  in  5  destination rt of the load in EX.
Redirect  in  1  MEM-stage PC redirect: (BranchEQ&Zero) | (BranchNE&!Zero) | Jump | JR.
ExtHold  in  1  freeze request.
PC_Write  out  1  PC load enable.
IF_ID_Write  out  1  IF/ID load enable.
Pipe_Enable  out  1  load enable for ID/EX, EX/MEM and MEM/WB.
IF_ID_Flush  out  1  zero IF/ID on the next edge.
ID_EX_Flush  out  1  zero ID/EX on the next edge (bubble).
EX_MEM_Flush  out  1  zero EX/MEM control on the next edge.
WB_Valid  out  1  MEM/WB holds a real instruction.
State  out  2  FSM state.
StallCount  out  CNT_WIDTH  load-use stall cycles.
FlushCount  out  CNT_WIDTH  redirects taken.
RetireCount  out  CNT_WIDTH  instructions retired.

Behaviour:
- Stall and flush outputs are combinational (Mealy) from the inputs and the current state, so they act on the same edge. The FSM, valid bits and counters are registered.
- While reset=1:
  - Outputs: PC_Write=0, IF_ID_Write=0, Pipe_Enable=0, all three flushes=1, WB_Valid=0, counters=0.
  - Internal: State=RUN, all four valid bits (v_ifid, v_idex, v_exmem, v_memwb) cleared.
- Load-use hazard (lu) = ID_EX_MemRead & (ID_EX_Rt != 0) & ((ID_EX_Rt == ID_Rs) | (ID_EX_Rt == ID_Rt)) & v_idex & v_ifid.
- Priority per cycle: reset > ExtHold > Redirect > lu > normal.
- FSM states:
  - RUN=0: normal operation.
  - STALL=1: one bubble cycle.
  - HOLD=2: frozen.
- Transitions:
  - RUN + ExtHold -> HOLD.
  - RUN + Redirect -> RUN, with flush.
  - RUN + lu -> STALL.
  - STALL -> RUN unconditionally after one cycle, unless ExtHold -> HOLD.
  - HOLD + !ExtHold -> RUN.
- Per-cycle outputs:
  - Normal: all enables=1, flushes=0.
  - lu (in RUN): PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, Pipe_Enable=1. Exactly one bubble per load-use.
  - In STALL: lu is not re-evaluated; all enables=1, no flush.
  - Redirect: IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, all enables=1. The PC loads the redirect target. The three younger instructions are killed.
  - Redirect and lu in the same cycle: Redirect wins; no stall, StallCount unchanged.
  - HOLD: all enables=0, flushes=0. Valid bits and counters hold.
  - ExtHold and Redirect in the same cycle: hold wins. Redirect stays asserted because the EX/MEM register is frozen, so it is serviced on exit.
- Valid bits:
  - Advance when Pipe_Enable=1: v_memwb<=v_exmem, v_exmem<=v_idex&!EX_MEM_Flush, v_idex<=v_ifid&!ID_EX_Flush.
  - v_ifid<=!IF_ID_Flush when IF_ID_Write=1; holds when IF_ID_Write=0.
  - First valid WB occurs 4 cycles after reset release.
- WB_Valid=v_memwb.
- Counters:
  - RetireCount +1 per cycle with v_memwb & Pipe_Enable.
  - StallCount +1 per lu stall cycle.
  - FlushCount +1 per Redirect cycle actually serviced, i.e. not held.
  - All saturate at all-ones; no wrap.
- Reset mid-stall or mid-hold returns immediately to RUN with the reset values above.

Decomposition:
- Shared package mips_pipe_pkg:
  - State encodings RUN/STALL/HOLD and STATE_W=2.
  - REG_ADDR_W=5 and REG_ZERO=5'd0.
- One sub-module: sat_counter (CNT_WIDTH, clk, reset, inc, count), instantiated three times.

Test Plan:
- Reset: hold reset 3 cycles, release, straight-line code -> enables=1 from the first post-reset cycle, WB_Valid rises on the 4th edge, RetireCount=1 one edge later.
- Load-use: lw $8,0($16) then add $9,$8,$10 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, State=STALL for 1 cycle; StallCount=1. Repeat with ID_EX_Rt=0 -> no stall.
- Taken beq with Redirect=1 for 1 cycle -> all three flushes=1 in that cycle; the next 3 cycles have WB_Valid=0 for the killed slots; FlushCount=1.
- Redirect and lu in the same cycle -> no stall, flushes=1, StallCount unchanged, FlushCount +1.
- ExtHold for 5 cycles mid-stream -> State=HOLD, all enables=0, counters frozen; on release execution resumes with no lost or duplicated retirement (RetireCount matches the instruction count).
- Saturation: CNT_WIDTH=4, 20 load-use stalls -> StallCount stays at 15.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pipe_pkg
//  Purpose  : Shared definitions for the 5-stage MIPS pipeline control logic.
//             This package holds the sequencer state encodings, register-file
//             address constants, the bundled enable/flush types and the
//             load-use match helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mips_pipe_pkg;

  // Sequencer state encodings
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] RUN   = 2'd0;
  localparam logic [STATE_W-1:0] STALL = 2'd1;
  localparam logic [STATE_W-1:0] HOLD  = 2'd2;

  // Register-file addressing
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Load enables for the PC and the pipeline registers
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic pipe_enable;
  } enables_t;

  // Flush (zero-on-next-edge) requests for the pipeline registers
  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } flushes_t;

  // True when the load in EX writes a register that the instruction in ID
  // reads. $zero is never a real dependency because it is hard-wired.
  function automatic logic load_use_match(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] ex_rt,
    input logic [REG_ADDR_W-1:0] id_rs,
    input logic [REG_ADDR_W-1:0] id_rt
  );
    return mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that stops at all-ones instead of wrapping.
//  Ports    : clk    in   system clock, rising edge
//             reset  in   asynchronous active-high reset (clears count)
//             inc    in   add one on the next edge when not saturated
//             count  out  current count value
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] C_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_control_unit
//  Purpose  : Pipeline sequencer for the 5-stage MIPS core. It stalls on
//             load-use hazards, flushes on MEM-stage redirects, freezes on an
//             external hold, tracks per-stage valid bits and keeps saturating
//             stall/flush/retire counters.
//  Ports    : clk           in   system clock, rising edge
//             reset         in   asynchronous active-high reset
//             ID_Rs/ID_Rt   in   source registers of the instruction in ID
//             ID_EX_MemRead in   instruction in EX is a load
//             ID_EX_Rt      in   destination of the load in EX
//             Redirect      in   MEM-stage PC redirect (taken branch/jump/jr)
//             ExtHold       in   freeze request (single-step / debug)
//             PC_Write      out  PC load enable
//             IF_ID_Write   out  IF/ID load enable
//             Pipe_Enable   out  ID/EX, EX/MEM, MEM/WB load enable
//             IF_ID_Flush   out  zero IF/ID on the next edge
//             ID_EX_Flush   out  zero ID/EX on the next edge (bubble)
//             EX_MEM_Flush  out  zero EX/MEM control on the next edge
//             WB_Valid      out  MEM/WB holds a real instruction
//             State         out  sequencer state (RUN/STALL/HOLD)
//             StallCount    out  load-use stall cycles
//             FlushCount    out  redirects serviced
//             RetireCount   out  instructions retired
//  Revision : 1.0  initial release
// ============================================================================
module hazard_control_unit
  import mips_pipe_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
  input  logic                  Redirect,
  input  logic                  ExtHold,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  Pipe_Enable,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Flush,
  output logic                  EX_MEM_Flush,
  output logic                  WB_Valid,
  output logic [STATE_W-1:0]    State,
  output logic [CNT_WIDTH-1:0]  StallCount,
  output logic [CNT_WIDTH-1:0]  FlushCount,
  output logic [CNT_WIDTH-1:0]  RetireCount
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;

  // One valid bit per pipeline register
  logic r_v_ifid;
  logic r_v_idex;
  logic r_v_exmem;
  logic r_v_memwb;

  logic     w_lu;
  logic     w_stall;
  logic     w_redirect_svc;
  logic     w_retire;
  enables_t w_en;
  flushes_t w_fl;

  // A hazard only exists when both the load and its consumer are real
  // instructions; bubbles and flushed slots must never cause a stall.
  assign w_lu = load_use_match(ID_EX_MemRead, ID_EX_Rt, ID_Rs, ID_Rt) &
                r_v_idex & r_v_ifid;

  // --------------------------------------------------------------------------
  // Mealy control: enables and flushes act on the same edge as the inputs.
  // Priority: reset > ExtHold > Redirect > load-use > normal.
  // The cycle that leaves HOLD is evaluated like a RUN cycle so that a
  // redirect or load-use that was pending across the freeze is serviced.
  // In STALL the bubble already sits in ID/EX, so load-use is not re-checked.
  // --------------------------------------------------------------------------
  always_comb begin
    w_en           = '1;
    w_fl           = '0;
    w_state_next   = RUN;
    w_stall        = 1'b0;
    w_redirect_svc = 1'b0;

    if (reset) begin
      w_en = '0;
      w_fl = '1;
    end else if (ExtHold) begin
      // Everything frozen; a concurrent redirect stays asserted because
      // EX/MEM does not move, so it is picked up on exit.
      w_en         = '0;
      w_state_next = HOLD;
    end else if (Redirect) begin
      // Kill the three younger instructions; the PC takes the target.
      w_fl           = '1;
      w_redirect_svc = 1'b1;
    end else if ((r_state != STALL) && w_lu) begin
      // Hold PC and IF/ID, inject one bubble into ID/EX.
      w_en.pc_write    = 1'b0;
      w_en.if_id_write = 1'b0;
      w_fl.id_ex       = 1'b1;
      w_stall          = 1'b1;
      w_state_next     = STALL;
    end
  end

  assign PC_Write     = w_en.pc_write;
  assign IF_ID_Write  = w_en.if_id_write;
  assign Pipe_Enable  = w_en.pipe_enable;
  assign IF_ID_Flush  = w_fl.if_id;
  assign ID_EX_Flush  = w_fl.id_ex;
  assign EX_MEM_Flush = w_fl.ex_mem;

  // --------------------------------------------------------------------------
  // State and valid-bit tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_v_ifid  <= 1'b0;
      r_v_idex  <= 1'b0;
      r_v_exmem <= 1'b0;
      r_v_memwb <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_en.pipe_enable) begin
        r_v_memwb <= r_v_exmem;
        r_v_exmem <= r_v_idex & ~w_fl.ex_mem;
        r_v_idex  <= r_v_ifid & ~w_fl.id_ex;
      end
      // A fetch slot becomes valid whenever IF/ID loads without a flush.
      if (w_en.if_id_write) begin
        r_v_ifid <= ~w_fl.if_id;
      end
    end
  end

  assign State    = r_state;
  assign WB_Valid = r_v_memwb;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  assign w_retire = r_v_memwb & w_en.pipe_enable;

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (StallCount)
  );

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_redirect_svc),
    .count (FlushCount)
  );

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_retire),
    .count (RetireCount)
  );

endmodule
`default_nettype wire
